bin2bcd_seq: RTL

- Sequential binary-to-BCD converter using the iterative double-dabble (shift-add-3) method.
- Sits directly upstream of the 8-bit two-digit BCD adder: converts binary operands into packed BCD digits for that adder.
- Uses a start/busy/done handshake and converts one input bit per clock.
- With defaults, an 8-bit binary value becomes 3 packed BCD digits; the low 8 bits of the result are the adder's two-digit operand.

---
 rtl/bin2bcd_seq.sv | 107 ++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per clock,
// start/busy/done handshake, registered outputs with overflow flag.

module bin2bcd_dig_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);
  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(BIN_W+1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [W-1:0]     work_q, work_d, work_adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic             done_q, done_d;
  logic [W-1:0]     bcd_q, bcd_d;
  logic             ovf_q, ovf_d;

  // add-3 correction on every digit in parallel, ahead of the shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin2bcd_dig_adj u_adj (
      .d_i (work_q[4*g +: 4]),
      .d_o (work_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          work_d    = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        work_d    = {work_adj[W-2:0], bin_q[BIN_W-1]};
        bin_d     = {bin_q[BIN_W-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | work_adj[W-1];
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_W-1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = work_d;
          ovf_d   = ovf_acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
endmodule
